// File: rtl/cdc_fifo_gray_batch_rd_pkg.sv
// Small helpers shared by the batch-reading CDC FIFO read side.
package cdc_fifo_gray_batch_rd_pkg;

  // Unsigned minimum, used to clamp a batch to the data actually present.
  function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

  // Gather timer width: wide enough to reach timeout-1 and then saturate.
  function automatic int unsigned timer_width(input int unsigned timeout);
    return (timeout < 2) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/binary_to_gray.sv
// Combinational binary to gray-code conversion.
module binary_to_gray #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] A_i,
  output logic [N-1:0] Z_o
);

  assign Z_o = A_i ^ (A_i >> 1);

endmodule

// File: rtl/gray_to_binary.sv
// Combinational gray-code to binary conversion.
module gray_to_binary #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] A_i,
  output logic [N-1:0] Z_o
);

  // Each binary bit is the parity of the gray bits at and above it.
  for (genvar i = 0; i < N; i++) begin : g_bit
    assign Z_o[i] = ^A_i[N-1:i];
  end

endmodule

// File: rtl/spill_register.sv
// Two-entry spill register: fully registered valid/ready cut.
// Handshake: a beat transfers on a clock edge where valid and ready are both 1;
// once valid is raised, data is held stable until it is accepted.
module spill_register #(
  parameter type T = logic
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic valid_i,
  output logic ready_o,
  input  T     data_i,
  output logic valid_o,
  input  logic ready_i,
  output T     data_o
);

  T     a_data_q, b_data_q;
  logic a_full_q, b_full_q;
  logic a_fill, a_drain, b_fill, b_drain;

  assign a_fill  = valid_i & ready_o;
  assign a_drain = a_full_q & ~b_full_q;
  assign b_fill  = a_drain & ~ready_i;
  assign b_drain = b_full_q & ready_i;

  // Stage A takes new beats; it empties into the output or into stage B.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_data_q <= '0;
      a_full_q <= 1'b0;
    end else begin
      if (a_fill) a_data_q <= data_i;
      if (a_fill || a_drain) a_full_q <= a_fill;
    end
  end

  // Stage B parks the older beat while the consumer stalls.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      b_data_q <= '0;
      b_full_q <= 1'b0;
    end else begin
      if (b_fill) b_data_q <= a_data_q;
      if (b_fill || b_drain) b_full_q <= b_fill;
    end
  end

  assign valid_o = a_full_q | b_full_q;
  assign ready_o = ~a_full_q | ~b_full_q;
  assign data_o  = b_full_q ? b_data_q : a_data_q;

endmodule

// File: rtl/sync.sv
// Multi-stage flip-flop synchronizer for a single bit.
module sync #(
  parameter int unsigned STAGES      = 2,
  parameter bit          RESET_VALUE = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic serial_i,
  output logic serial_o
);

  logic [STAGES-1:0] reg_q;

  // Shift the asynchronous input through the synchronizer chain.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      reg_q <= {STAGES{RESET_VALUE}};
    end else begin
      reg_q <= {reg_q[STAGES-2:0], serial_i};
    end
  end

  assign serial_o = reg_q[STAGES-1];

endmodule

// File: rtl/cdc_fifo_gray_batch_rd.sv
// Read side of a gray-pointer CDC FIFO that emits data in batches.
// Output handshake: a beat transfers on a clock edge where valid_o and ready_i
// are both 1; while valid_o is 1 and ready_i is 0, data_o/last_o hold steady.
module cdc_fifo_gray_batch_rd
  import cdc_fifo_gray_batch_rd_pkg::*;
#(
  parameter int unsigned WIDTH       = 1,
  parameter type         T           = logic [WIDTH-1:0],
  parameter int unsigned LOG_DEPTH   = 3,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned BURST_LEN   = 4,
  parameter int unsigned TIMEOUT     = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  T                   async_data_i [2**LOG_DEPTH],
  input  logic [LOG_DEPTH:0] async_wptr_i,
  output logic [LOG_DEPTH:0] async_rptr_o,
  input  logic               flush_i,
  output T                   data_o,
  output logic               valid_o,
  input  logic               ready_i,
  output logic               last_o,
  output logic [LOG_DEPTH:0] level_o,
  output logic               busy_o
);

  localparam int unsigned PW    = LOG_DEPTH + 1;
  localparam int unsigned DEPTH = 2**LOG_DEPTH;
  localparam int unsigned TW    = timer_width(TIMEOUT);
  localparam logic [PW-1:0] BURST_LEN_P  = PW'(BURST_LEN);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);

  if (BURST_LEN < 1 || BURST_LEN > DEPTH) begin : g_bad_burst_len
    $error("BURST_LEN must lie in 1..2**LOG_DEPTH");
  end
  if (LOG_DEPTH < 1) begin : g_bad_log_depth
    $error("LOG_DEPTH must be at least 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync_stages
    $error("SYNC_STAGES must be at least 2");
  end

  typedef enum logic [1:0] {IDLE, GATHER, BURST} state_e;

  typedef struct packed {
    T     data;
    logic last;
  } beat_t;

  state_e        state_q;
  logic [TW-1:0] timer_q;
  logic [PW-1:0] beat_q, len_q;
  logic [PW-1:0] rptr_bin_q, rptr_next, rptr_next_gray;
  logic [PW-1:0] wptr_gray_sync, wptr_bin;
  logic          int_valid, int_ready, int_hs, int_last, go_burst;
  beat_t         int_beat, out_beat;

  // Bring the foreign write pointer into this domain bit by bit.
  for (genvar i = 0; i < PW; i++) begin : g_wptr_sync
    sync #(.STAGES(SYNC_STAGES), .RESET_VALUE(1'b0)) i_sync (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .serial_i (async_wptr_i[i]),
      .serial_o (wptr_gray_sync[i])
    );
  end

  gray_to_binary #(.N(PW)) i_wptr_g2b (
    .A_i (wptr_gray_sync),
    .Z_o (wptr_bin)
  );

  assign rptr_next = rptr_bin_q + PW'(1);

  binary_to_gray #(.N(PW)) i_rptr_b2g (
    .A_i (rptr_next),
    .Z_o (rptr_next_gray)
  );

  // Pointers are one bit wider than the address, so the difference is 0..DEPTH.
  assign level_o = wptr_bin - rptr_bin_q;

  assign go_burst = (level_o >= BURST_LEN_P)
                 || ((TIMEOUT != 0) && (timer_q == TIMEOUT_LAST))
                 || flush_i;

  assign int_valid     = (state_q == BURST);
  assign int_hs        = int_valid & int_ready;
  assign int_last      = (beat_q == (len_q - PW'(1)));
  assign int_beat.data = async_data_i[rptr_bin_q[LOG_DEPTH-1:0]];
  assign int_beat.last = int_last;
  assign busy_o        = (state_q != IDLE);

  // Batch FSM: wait for data, gather until full/timeout/flush, then pop a batch.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      beat_q       <= '0;
      len_q        <= '0;
      rptr_bin_q   <= '0;
      async_rptr_o <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (level_o != '0) begin
            state_q <= GATHER;
            timer_q <= '0;
          end
        end
        GATHER: begin
          if (timer_q != '1) timer_q <= timer_q + TW'(1);
          if (go_burst) begin
            state_q <= BURST;
            len_q   <= PW'(min_u(32'(level_o), BURST_LEN));
            beat_q  <= '0;
          end
        end
        BURST: begin
          if (int_hs) begin
            rptr_bin_q   <= rptr_next;
            async_rptr_o <= rptr_next_gray;
            beat_q       <= beat_q + PW'(1);
            if (int_last) begin
              // Level still counts the beat being popped, so "> 1" means data remains.
              if (level_o > PW'(1)) begin
                state_q <= GATHER;
                timer_q <= '0;
              end else begin
                state_q <= IDLE;
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  spill_register #(.T(beat_t)) i_spill (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .valid_i (int_valid),
    .ready_o (int_ready),
    .data_i  (int_beat),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .data_o  (out_beat)
  );

  assign data_o = out_beat.data;
  assign last_o = out_beat.last;

endmodule
